// File: rtl/pixel_arb_pkg.sv
// Shared types and default sizes for the pixel RAM arbiter.
package pixel_arb_pkg;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FIFO_DEPTH   = 8;
    localparam int DEF_LOW_WATER    = 4;
    localparam int DEF_FRAME_PIXELS = 65536;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VGA,
        GNT_CPU
    } grant_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding prefetched scan-out pixels.
// Flush and reset empty it; a pop on empty is ignored.
module pixel_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/pixel_ram_arbiter.sv
// Shares the single-port pixel RAM between CPU loads/stores and VGA scan-out.
// Scan-out pixels are prefetched into a FIFO; the CPU is only stalled when
// the FIFO level drops below LOW_WATER.
// Optional macro PIXEL_ARB_STATS_EN adds saturating stall/underflow counters.
module pixel_ram_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int LOW_WATER    = DEF_LOW_WATER,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_enable,
    input  logic              pix_pop,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              underflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
`ifdef PIXEL_ARB_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LVL_W = CNT_W + 1;

    arb_state_t        state;
    grant_t            grant;
    logic [ADDR_W-1:0] scan_addr;
    logic              inflight;
    logic              rd_pend;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [LVL_W-1:0]  level;
    logic              vga_can;
    logic              drop;
    logic              fill_done;
    logic              underflow_evt;

    // Credit includes the read already on its way back from the RAM.
    assign level   = {1'b0, fifo_count} + LVL_W'(inflight);
    assign vga_can = (state != IDLE) && (level < LVL_W'(FIFO_DEPTH));
    assign drop    = (state != IDLE) && !vga_enable;

    // One RAM access per cycle; VGA only outranks a waiting CPU when running low.
    always_comb begin
        grant = GNT_NONE;
        if (reset)
            grant = GNT_NONE;
        else if (vga_can && (level < LVL_W'(LOW_WATER) || !cpu_req))
            grant = GNT_VGA;
        else if (cpu_req)
            grant = GNT_CPU;
    end

    assign cpu_ready = (grant == GNT_CPU);
    assign ram_we    = cpu_ready && cpu_we;
    assign ram_addr  = cpu_ready ? cpu_addr : scan_addr;
    assign ram_wdata = cpu_wdata;

    // Returning data from a read issued before scan-out was switched off is dropped.
    assign fifo_flush    = (state == IDLE) || drop;
    assign fifo_push     = inflight && !fifo_flush;
    assign pix_valid     = (state == RUN) && !fifo_empty;
    assign fifo_pop      = pix_pop && pix_valid;
    assign underflow_evt = pix_pop && fifo_empty && (state == RUN);
    // No pops happen in FILL, so the post-edge count is count + push.
    assign fill_done     = fifo_full ||
                           (fifo_count == CNT_W'(FIFO_DEPTH - 1) && fifo_push);

    pixel_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (ram_q),
        .dout  (pix_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Scan-out FSM with scan address, inflight marker and sticky underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scan_addr <= '0;
            inflight  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            inflight <= (grant == GNT_VGA);
            if (grant == GNT_VGA)
                scan_addr <= (scan_addr == ADDR_W'(FRAME_PIXELS - 1)) ? '0 : scan_addr + 1'b1;
            case (state)
                IDLE: if (vga_enable) begin
                    state     <= FILL;
                    underflow <= 1'b0;
                end
                FILL: if (fill_done)
                    state <= RUN;
                RUN: if (underflow_evt)
                    underflow <= 1'b1;
                default: state <= IDLE;
            endcase
            if (drop) begin
                state     <= IDLE;
                scan_addr <= '0;
                inflight  <= 1'b0;
            end
        end
    end

    // CPU read return: pulse valid the cycle after grant, hold data until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rdata_q <= '0;
        end else begin
            rd_pend <= cpu_ready && !cpu_we;
            if (rd_pend)
                rdata_q <= ram_q;
        end
    end

    assign cpu_rvalid = rd_pend;
    assign cpu_rdata  = rd_pend ? ram_q : rdata_q;

`ifdef PIXEL_ARB_STATS_EN
    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt     <= '0;
            underflow_cnt <= '0;
        end else begin
            if (cpu_req && !cpu_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (underflow_evt && underflow_cnt != '1)
                underflow_cnt <= underflow_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter. Main instance uses default parameters;
// a second instance with LOW_WATER = 1 lets the CPU drain the FIFO so
// underflow can be provoked.
module tb_pixel_ram_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid;
    logic [15:0] cpu_addr, ram_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, pix_data, ram_wdata, ram_q;
    logic        vga_enable, pix_pop, pix_valid, underflow, ram_we;

    logic        b_cpu_req, b_cpu_we, b_cpu_ready, b_cpu_rvalid;
    logic [15:0] b_cpu_addr, b_ram_addr;
    logic [7:0]  b_cpu_wdata, b_cpu_rdata, b_pix_data, b_ram_wdata, b_ram_q;
    logic        b_vga_enable, b_pix_pop, b_pix_valid, b_underflow, b_ram_we;

`ifdef PIXEL_ARB_STATS_EN
    logic [31:0] stall_cnt, b_stall_cnt;
    logic [15:0] underflow_cnt, b_underflow_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] nxt;
    logic        hit;

    pixel_ram_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vga_enable(vga_enable), .pix_pop(pix_pop), .pix_valid(pix_valid),
        .pix_data(pix_data), .underflow(underflow),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
`ifdef PIXEL_ARB_STATS_EN
        , .stall_cnt(stall_cnt), .underflow_cnt(underflow_cnt)
`endif
    );

    pixel_ram_arbiter #(.LOW_WATER(1)) u_dut_lw1 (
        .clk(clk), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ready(b_cpu_ready), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .vga_enable(b_vga_enable), .pix_pop(b_pix_pop), .pix_valid(b_pix_valid),
        .pix_data(b_pix_data), .underflow(b_underflow),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_q(b_ram_q)
`ifdef PIXEL_ARB_STATS_EN
        , .stall_cnt(b_stall_cnt), .underflow_cnt(b_underflow_cnt)
`endif
    );

    // Main RAM model: RAM[i] = i[7:0] after reset, registered read.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    // Second RAM model: read-only, returns the low address byte.
    always @(posedge clk) b_ram_q <= b_ram_addr[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the drive/sample window just after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // From IDLE: enable scan-out, expect addresses 0..7 back-to-back, RUN after 9 cycles.
    task automatic fill_check(input string tag);
        cyc();
        vga_enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk({tag, "_addr"}, ram_addr, k);
            chk({tag, "_we"}, ram_we, 0);
            chk({tag, "_valid_fill"}, pix_valid, 0);
        end
        cyc();
        chk({tag, "_valid_c9"}, pix_valid, 0);
        cyc();
        chk({tag, "_valid_run"}, pix_valid, 1);
        chk({tag, "_first_pix"}, pix_data, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h55;
        vga_enable = 1'b0; pix_pop = 1'b0;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 16'h0045; b_cpu_wdata = 8'h3C;
        b_vga_enable = 1'b0; b_pix_pop = 1'b0;
        nxt = 16'h0000;
        hit = 1'b0;

        // Reset state, with a CPU write request pending to show it is held off.
        repeat (3) cyc();
        chk("rst_ready", cpu_ready, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_underflow", underflow, 0);
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0;
        cyc();
        chk("idle_addr", ram_addr, 16'h0000);
        chk("idle_valid", pix_valid, 0);

        // Initial fill and in-order pops.
        fill_check("fill1");
        for (int k = 0; k < 4; k++) begin
            pix_pop = 1'b1;
            #1;
            chk("pop_valid", pix_valid, 1);
            chk("pop_data", pix_data, mem[nxt]);
            nxt = nxt + 1'b1;
            cyc();
        end
        pix_pop = 1'b0;
        repeat (12) cyc();

        // CPU write then read-back with the FIFO full.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'hAA;
        #1;
        chk("wr_ready", cpu_ready, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 16'h0100);
        chk("wr_wdata", ram_wdata, 8'hAA);
        cyc();
        cpu_we = 1'b0;
        #1;
        chk("rd_ready", cpu_ready, 1);
        chk("rd_we", ram_we, 0);
        chk("rd_addr", ram_addr, 16'h0100);
        cyc();
        cpu_req = 1'b0;
        #1;
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", cpu_rdata, 8'hAA);
        cyc();
        chk("rd_rvalid_pulse", cpu_rvalid, 0);
        chk("rd_rdata_held", cpu_rdata, 8'hAA);

        // Continuous CPU reads plus a pop every cycle: CPU wins at levels 8..4,
        // then VGA holds the level at 3 and the FIFO never runs dry.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0233; pix_pop = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("cont_ready", cpu_ready, (k < 5));
            chk("cont_rvalid", cpu_rvalid, (k >= 1 && k < 6));
            if (k == 1) chk("cont_rdata", cpu_rdata, 8'h33);
            chk("cont_valid", pix_valid, 1);
            chk("cont_data", pix_data, mem[nxt]);
            chk("cont_underflow", underflow, 0);
            nxt = nxt + 1'b1;
            cyc();
        end
        cpu_req = 1'b0; pix_pop = 1'b0;
        repeat (12) cyc();

        // Frame wrap: pop every cycle until the fetch address reaches 0xFFFF.
        pix_pop = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            #1;
            chk("wrap_data", pix_data, mem[nxt]);
            nxt = nxt + 1'b1;
            if (ram_addr == 16'hFFFF) begin
                hit = 1'b1;
                break;
            end
            cyc();
        end
        chk("wrap_reached", hit, 1);
        chk("wrap_vga_grant", cpu_ready, 0);
        cyc();
        chk("wrap_addr0", ram_addr, 16'h0000);
        chk("wrap_data0", pix_data, mem[nxt]);
        nxt = nxt + 1'b1;
        cyc();
        chk("wrap_addr1", ram_addr, 16'h0001);
        for (int k = 0; k < 10; k++) begin
            chk("wrap_tail_data", pix_data, mem[nxt]);
            nxt = nxt + 1'b1;
            cyc();
        end
        pix_pop = 1'b0;
        chk("wrap_underflow", underflow, 0);

        // Disable, then re-enable and drop scan-out with a read inflight.
        vga_enable = 1'b0;
        cyc();
        cyc();
        chk("dis_scan_clear", ram_addr, 16'h0000);
        chk("dis_valid", pix_valid, 0);
        vga_enable = 1'b1;
        cyc();
        chk("inf_grant_addr", ram_addr, 16'h0000);
        chk("inf_grant_ready", cpu_ready, 0);
        cyc();
        vga_enable = 1'b0;
        cyc();
        chk("inf_idle_addr", ram_addr, 16'h0000);
        chk("inf_idle_valid", pix_valid, 0);
        fill_check("refill");

        // Underflow on the LOW_WATER = 1 instance: CPU drains the FIFO to empty.
        b_vga_enable = 1'b1;
        repeat (11) cyc();
        chk("b_full_valid", b_pix_valid, 1);
        chk("b_underflow0", b_underflow, 0);
        b_cpu_req = 1'b1; b_pix_pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("b_valid", b_pix_valid, (k < 8));
            chk("b_underflow", b_underflow, (k >= 9));
            if (k < 8) chk("b_data", b_pix_data, k);
            if (k == 0) chk("b_ready", b_cpu_ready, 1);
            if (k == 0) chk("b_wdata", b_ram_wdata, 8'h3C);
            if (k == 1) chk("b_rdata", b_cpu_rdata, 8'h45);
            chk("b_we", b_ram_we, 0);
            chk("b_rvalid", b_cpu_rvalid, (k >= 1 && k < 9));
            cyc();
        end
        b_cpu_req = 1'b0; b_pix_pop = 1'b0;
        repeat (3) cyc();
        chk("b_sticky_run", b_underflow, 1);
        b_vga_enable = 1'b0;
        cyc();
        cyc();
        chk("b_sticky_idle", b_underflow, 1);
        b_vga_enable = 1'b1;
        cyc();
        chk("b_clear_on_fill", b_underflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_ram_arbiter.md
Name: pixel_ram_arbiter

Overview:
- Shares the single-port pixel RAM between the CPU memory stage (pixel stores and loads) and VGA scan-out.
- Prefetches sequential scan-out pixels into a small FIFO so VGA always has data, and stalls the CPU only when the FIFO runs low.
- Sits between the EXECUTE-MEMORY pipeline register outputs, the pixel RAM and the VGA pixel path, all in the `clk` domain.

Parameters:
- ADDR_W, 16, pixel RAM address width.
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 8, prefetch FIFO entries; power of two, at least 4.
- LOW_WATER, 4, fill level below which VGA has priority; must satisfy 1 ≤ LOW_WATER < FIFO_DEPTH.
- FRAME_PIXELS, 65536, pixels per frame; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU pixel address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  CPU access granted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_rdata  out  DATA_W  CPU read data.
- vga_enable  in  1  scan-out enable switch (level).
- pix_pop  in  1  VGA consumes one pixel.
- pix_valid  out  1  FIFO head valid.
- pix_data  out  DATA_W  FIFO head pixel.
- underflow  out  1  sticky: pop while empty in RUN.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data; valid the cycle after the address is presented.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values:
  - FSM = IDLE, scan_addr = 0, FIFO empty, inflight = 0.
  - cpu_rvalid = 0, cpu_rdata = 0, underflow = 0, pix_valid = 0.
  - During reset, cpu_ready = 0 and ram_we = 0.
- FSM states: IDLE, FILL, RUN.
  - IDLE: no VGA fetches, FIFO held flushed, scan_addr = 0. Goes to FILL when vga_enable = 1.
  - FILL: VGA fetches enabled, pix_valid = 0. Goes to RUN when the FIFO count reaches FIFO_DEPTH.
  - RUN: pix_valid = !empty.
  - FILL or RUN go to IDLE on vga_enable = 0. The FIFO is flushed and scan_addr cleared at that edge.
- Credit: level = fifo_count + inflight, where inflight (0 or 1) marks a VGA read issued last cycle. vga_can = state ≠ IDLE && level < FIFO_DEPTH.
- Arbitration, one RAM access per cycle, decided combinationally:
  - VGA wins if vga_can && (level < LOW_WATER || !cpu_req).
  - Otherwise the CPU wins if cpu_req.
  - Otherwise no access: ram_we = 0, ram_addr = scan_addr.
- VGA grant: ram_addr = scan_addr, ram_we = 0, inflight set. scan_addr increments and wraps from FRAME_PIXELS-1 to 0. Next cycle ram_q is pushed into the FIFO.
- CPU grant: ram_addr = cpu_addr, cpu_ready = 1.
  - Write (cpu_we = 1): ram_we = 1, ram_wdata = cpu_wdata, committed at that edge.
  - Read (cpu_we = 0): next cycle cpu_rvalid = 1 and cpu_rdata = ram_q, held until the next CPU read completes. cpu_rvalid is a one-cycle pulse.
- FIFO: push and pop in the same cycle are allowed, count unchanged. Overflow cannot occur because of the credit rule. pix_pop when pix_valid = 0 is ignored.
- underflow: set on pix_pop && empty && state == RUN. Cleared on reset or on entry to FILL.
- vga_enable falling while a VGA read is inflight: the returning data is discarded and the FIFO stays empty.
- Latency: first pixel reaches the FIFO 2 cycles after FILL entry. Minimum FILL→RUN time is FIFO_DEPTH+1 cycles when the CPU is idle.

Optional Feature:
- Macro: PIXEL_ARB_STATS_EN.
- With the macro:
  - Adds outputs stall_cnt[31:0] and underflow_cnt[15:0], both reset to 0, both saturating.
  - stall_cnt increments each cycle cpu_req && !cpu_ready.
  - underflow_cnt increments per underflow event.
- Without the macro: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pixel_arb_pkg:
  - enum arb_state_t {IDLE, FILL, RUN}.
  - enum grant_t {GNT_NONE, GNT_VGA, GNT_CPU}.
  - Default width constants.
- One sub-module: pixel_fifo, a synchronous FIFO.
  - Parameters: DEPTH, DATA_W.
  - Ports: push, pop, flush, din, dout, count, empty, full.

Test Plan:
- Reset, then vga_enable = 1, CPU idle, RAM[i] = i[7:0] → addresses 0..7 fetched on consecutive cycles, RUN entered at cycle 9, pix_data = 0x00, pops return 0x01, 0x02, ….
- RUN with FIFO full, CPU writes 0xAA to 0x0100 → cpu_ready in the same cycle, ram_we = 1, a read of 0x0100 returns cpu_rvalid with 0xAA one cycle after its grant.
- Continuous cpu_req and VGA pops every cycle → cpu_ready low whenever level < 4, FIFO never empty, underflow stays 0.
- scan_addr at 0xFFFF with FRAME_PIXELS = 65536 → next fetch address 0x0000, no gap.
- Pop with pix_valid = 0 in RUN → underflow = 1 and sticky; drop vga_enable then re-enable → underflow cleared on FILL entry.
- vga_enable drops in the cycle after a VGA grant → inflight data not pushed, FIFO count 0, state IDLE, scan_addr = 0.
